// File: rtl/simon_pkg.sv
// Shared Simon definitions: z-sequence constants, width-generic rotations,
// the Feistel round function and the decryptor state encoding.
package simon_pkg;

  localparam logic [61:0] Z0 = 62'h3E8958737D12B0E6;
  localparam logic [61:0] Z1 = 62'h23BE4C2D477C985A;
  localparam logic [61:0] Z2 = 62'h2BDC0D262847E5B3;
  localparam logic [61:0] Z3 = 62'h36EB19781229CD0F;
  localparam logic [61:0] Z4 = 62'h3479AD88170CA4EF;

  typedef enum logic [2:0] {
    NOKEY  = 3'd0,
    KEYEXP = 3'd1,
    READY  = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Rotations work on the low n bits of a 64-bit carrier; callers slice the result.
  function automatic logic [63:0] rotl(input logic [63:0] v, input int a, input int n);
    logic [63:0] mask;
    logic [63:0] vm;
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    vm   = v & mask;
    return ((vm << a) | (vm >> (n - a))) & mask;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int a, input int n);
    return rotl(v, (n - a) % n, n);
  endfunction

  function automatic logic [63:0] round_f(input logic [63:0] v, input int n);
    return (rotl(v, 1, n) & rotl(v, 8, n)) ^ rotl(v, 2, n);
  endfunction

  function automatic logic z_bit(input int j, input int t);
    logic [61:0] z;
    logic [61:0] sh;
    case (j)
      0:       z = Z0;
      1:       z = Z1;
      2:       z = Z2;
      3:       z = Z3;
      default: z = Z4;
    endcase
    sh = z >> (61 - (t % 62));
    return sh[0];
  endfunction

endpackage

// File: rtl/simon_key_sched.sv
// Simon key expansion: one round key per cycle into a T-entry store, with a
// two-word read port (ks[rd_idx] and ks[rd_idx-1]) for the round datapath.
module simon_key_sched
  import simon_pkg::*;
#(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int T  = 32,
  parameter int J  = 0,
  parameter int CW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_load,
  input  logic [M*N-1:0] key,
  input  logic [CW-1:0]  rd_idx,
  output logic [N-1:0]   ks_rd,
  output logic [N-1:0]   ks_rd2,
  output logic           done
);

  logic [M*N-1:0] key_q;
  logic [CW-1:0]  c;
  logic           active;
  logic [N-1:0]   ks [T];
  logic [N-1:0]   new_word;
  logic [N-1:0]   tmp;
  logic [CW-1:0]  c_m1;
  logic [CW-1:0]  c_m3;
  logic [CW-1:0]  c_mm;
  logic           zb;

  function automatic logic [N-1:0] rotr_n(input logic [N-1:0] v, input int a);
    logic [63:0] w;
    w = rotr(64'(v), a, N);
    return w[N-1:0];
  endfunction

  assign c_m1 = c - CW'(1);
  assign c_m3 = c - CW'(3);
  assign c_mm = c - CW'(M);
  assign zb   = z_bit(J, (c >= CW'(M)) ? (int'(c) - M) : 0);
  assign done = active && (c == CW'(T - 1));

  // The first M entries are the master key words; later ones use the recurrence.
  always_comb begin
    new_word = '0;
    tmp      = '0;
    if (c < CW'(M)) begin
      new_word = key_q[c*N +: N];
    end else begin
      tmp = rotr_n(ks[c_m1], 3);
      if (M == 4) tmp = tmp ^ ks[c_m3];
      tmp      = tmp ^ rotr_n(tmp, 1);
      new_word = ~ks[c_mm] ^ tmp ^ N'(zb) ^ N'(3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '0;
      c      <= '0;
      active <= 1'b0;
    end else if (key_load) begin
      key_q  <= key;
      c      <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (c == CW'(T - 1)) active <= 1'b0;
      else                 c      <= c + CW'(1);
    end
  end

  // The store itself needs no reset: it is rewritten in full before key_ready.
  always_ff @(posedge clk) begin
    if (active && !key_load) ks[c] <= new_word;
  end

  assign ks_rd  = ks[rd_idx];
  assign ks_rd2 = ks[rd_idx - CW'(1)];

endmodule

// File: rtl/simon_decryptor.sv
// Iterative Simon decryption core with a one-shot key expansion.
// Define SIMON_DEC_TWO_ROUND_EN to unroll two rounds per cycle (T must be even).
module simon_decryptor
  import simon_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32,
  parameter int J = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_load,
  input  logic [M*N-1:0] key,
  output logic           key_ready,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] ct,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] pt,
  output logic           busy,
  output state_e         state
);

  localparam int CW = (T > 1) ? $clog2(T) : 1;
`ifdef SIMON_DEC_TWO_ROUND_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  if (N < 9 || M < 2 || M > 4 || J < 0 || J > 4) begin : g_bad_params
    $error("simon_decryptor: unsupported N/M/J combination");
  end
`ifdef SIMON_DEC_TWO_ROUND_EN
  if (T % 2 != 0) begin : g_odd_t
    $error("simon_decryptor: two-round datapath needs an even round count");
  end
`endif

  state_e        state_nx;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic [N-1:0]  x1;
  logic [N-1:0]  y1;
  logic [N-1:0]  x_nx;
  logic [N-1:0]  y_nx;
  logic [CW-1:0] r;
  logic [N-1:0]  ks_rd;
  logic          ks_done;
  logic          last_round;

  function automatic logic [N-1:0] rf(input logic [N-1:0] v);
    logic [63:0] w;
    w = round_f(64'(v), N);
    return w[N-1:0];
  endfunction

`ifdef SIMON_DEC_TWO_ROUND_EN
  logic [N-1:0] ks_rd2;
`else
  logic [N-1:0] ks_rd2_unused;
`endif

  simon_key_sched #(
    .N  (N),
    .M  (M),
    .T  (T),
    .J  (J),
    .CW (CW)
  ) u_key_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .key      (key),
    .rd_idx   (r),
    .ks_rd    (ks_rd),
`ifdef SIMON_DEC_TWO_ROUND_EN
    .ks_rd2   (ks_rd2),
`else
    .ks_rd2   (ks_rd2_unused),
`endif
    .done     (ks_done)
  );

  assign last_round = (r == CW'(STEP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NOKEY;
    else        state <= state_nx;
  end

  // key_load wins over everything: it aborts any block and restarts expansion.
  always_comb begin
    state_nx = state;
    if (key_load) begin
      state_nx = KEYEXP;
    end else begin
      case (state)
        NOKEY:   state_nx = NOKEY;
        KEYEXP:  if (ks_done) state_nx = READY;
        READY:   if (in_valid) state_nx = ROUND;
        ROUND:   if (last_round) state_nx = DONE;
        DONE:    if (out_ready) state_nx = READY;
        default: state_nx = NOKEY;
      endcase
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never depends on ready, and out_valid/pt stay stable until accepted.
  assign in_ready  = (state == READY) && !key_load;
  assign out_valid = (state == DONE);
  assign key_ready = (state == READY) || (state == ROUND) || (state == DONE);
  assign busy      = (state == KEYEXP) || (state == ROUND);

  always_comb begin
    x1   = y;
    y1   = x ^ rf(y) ^ ks_rd;
`ifdef SIMON_DEC_TWO_ROUND_EN
    x_nx = y1;
    y_nx = x1 ^ rf(y1) ^ ks_rd2;
`else
    x_nx = x1;
    y_nx = y1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x  <= '0;
      y  <= '0;
      r  <= '0;
      pt <= '0;
    end else if (in_valid && in_ready) begin
      x <= ct[2*N-1:N];
      y <= ct[N-1:0];
      r <= CW'(T - 1);
    end else if (state == ROUND && !key_load) begin
      x <= x_nx;
      y <= y_nx;
      r <= r - CW'(STEP);
      if (last_round) pt <= {x_nx, y_nx};
    end
  end

endmodule

// File: doc/simon_decryptor.md
Name: simon_decryptor

Overview:
Standalone Simon block-cipher decryption core with valid/ready streaming handshakes, the receive-side counterpart to the team's iterative Simon encryptor.
- Key load: a key is loaded once and expanded into a T-entry round-key store.
- Decryption: each accepted ciphertext block is decrypted iteratively, applying round keys T-1 down to 0.
- Placement: sits between the link ciphertext stream and the plaintext consumer.

Parameters:
N, 16, word size in bits (block = 2N); N >= 9 required.
M, 4, key words (2, 3 or 4).
T, 32, round count.
J, 0, z-sequence index (0..4).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
key_load  in  1  one-cycle pulse; captures key and starts expansion
key  in  M*N  master key; word k_i = key[(i+1)*N-1 -: N], so k0 is at the LSBs
key_ready  out  1  round-key store valid
in_valid  in  1  ciphertext valid
in_ready  out  1  core can accept a ciphertext block
ct  in  2N  ciphertext {x,y}, x in the upper N bits
out_valid  out  1  plaintext valid
out_ready  in  1  consumer accepts plaintext
pt  out  2N  plaintext {x,y}
busy  out  1  high in KEYEXP or ROUND

Behaviour:
- Reset values: key_ready=0, in_ready=0, out_valid=0, pt=0, busy=0, state=NOKEY, counter=0.
- Notation: S^a denotes left rotation by a on N bits. Z_j is the standard 62-bit constant; z_j(t) = bit (61 - t mod 62) of Z_j.
- Key expansion:
  - ks[i] = k_i for i < M.
  - For i >= M: tmp = S^-3 ks[i-1]; if M==4, tmp ^= ks[i-3]; tmp ^= S^-1 tmp; ks[i] = ~ks[i-M] ^ tmp ^ z_j(i-M) ^ 3.
- Decryption round r: x' = y; y' = x ^ ((S^1 y) & (S^8 y)) ^ (S^2 y) ^ ks[r].
- States:
  - NOKEY: in_ready=0. On key_load, go to KEYEXP.
  - KEYEXP: the counter c runs 0..T-1 and writes ks[c] each cycle (one word per cycle). At c==T-1, go to READY and set key_ready=1 on the next cycle. Total time: T cycles after the key_load edge.
  - READY: in_ready=1. On in_valid&&in_ready, latch ct into {x,y}, set r=T-1, go to ROUND.
  - ROUND: apply one round per cycle with r decrementing. After the round with r==0, go to DONE. Exactly T cycles are spent in ROUND.
  - DONE: out_valid=1 and pt={x,y}, held stable until out_ready. On out_valid&&out_ready, go to READY and deassert out_valid on the next edge. in_ready=0 while in DONE (no overlap).
- Latency and throughput: ct handshake to out_valid is T+1 cycles. Peak throughput is one block per T+2 cycles when out_ready is held at 1.
- key_load in any state other than NOKEY:
  - Aborts the in-flight block; no output is produced for it.
  - Drops key_ready and out_valid on the next cycle and restarts KEYEXP with the new key.
  - A ct handshake in the same cycle as key_load is ignored (in_ready is forced low that cycle).
- key_load during KEYEXP restarts expansion at c=0 with the new key.
- Asserting rst_n low mid-operation clears all state; ks contents are don't-care until the next KEYEXP completes.
- pt holds its last value after its handshake; it is not cleared.

Optional Feature:
SIMON_DEC_TWO_ROUND_EN:
- Defined: the datapath unrolls two rounds per cycle (ks[r] then ks[r-1]), so ROUND lasts T/2 cycles and latency is T/2+1.
- Defined: T must be even; an elaboration check is required.
- Undefined: one round per cycle, as above.
- Key expansion timing is unchanged in both cases.

Decomposition:
- Package simon_pkg holds:
  - the Z0..Z4 62-bit constants;
  - rotl/rotr functions;
  - the round function f(v) = (S^1 v & S^8 v) ^ S^2 v;
  - state enum {NOKEY, KEYEXP, READY, ROUND, DONE}.
- Sub-module simon_key_sched contains the expansion counter, the ks register array and a read port indexed by r.
  - It has outputs ks_rd, ks_rd2 (r-1, used by the optional feature) and done.

Test Plan:
- Simon32/64 vector (N=16, M=4, T=32, J=0): key_load with key=64'h1918111009080100; wait for key_ready; ct=32'hc69be9bb -> pt=32'h65656877, with out_valid exactly 33 cycles after the ct handshake.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> pt stable, in_ready=0 throughout; a handshake then returns the core to READY and in_ready=1 on the next cycle.
- Back-to-back: stream 4 blocks with out_ready=1 -> each block takes 34 cycles and all plaintexts are correct against a reference model.
- Key change mid-ROUND: key_load with key=0 at round 10 -> no out_valid for the aborted block, key_ready=0 for 32 cycles; decrypting a ct produced by a golden model under key 0 then gives the correct plaintext.
- Reset mid-KEYEXP, then release -> key_ready=0 and in_ready=0 until a new key_load completes expansion.
- With SIMON_DEC_TWO_ROUND_EN defined: the Simon32/64 vector gives pt=32'h65656877 with out_valid 17 cycles after the ct handshake.
